// File: rtl/rotate_sequencer.sv
// Drives a combinational rotator with a held pattern and a stepping distance,
// and captures the rotator's result one cycle after every change it makes.
module rotate_sequencer #(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_toggle,
  input  logic [WIDTH-1:0] rot_out,
  output logic [WIDTH-1:0] rot_in,
  output logic [7:0]       distance,
  output logic             direction,
  output logic [WIDTH-1:0] pattern,
  output logic             step_done,
  output logic             running
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [8:0]       WRAP_AT  = 9'(WIDTH);

  typedef enum logic {
    STOPPED = 1'b0,
    RUN     = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [WIDTH-1:0] rot_in_reg, rot_in_next;
  logic [7:0]       distance_reg, distance_next;
  logic             direction_reg, direction_next;
  logic             capture_reg, capture_next;
  logic             capture_step_reg, capture_step_next;
  logic [WIDTH-1:0] pattern_reg, pattern_next;
  logic             step_done_reg, step_done_next;

  logic             step_due;
  logic [8:0]       distance_inc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= STOPPED;
    end else begin
      state_reg <= state_next;
    end
  end

  // stop beats start; load never blocks a state command
  always_comb begin
    state_next = state_reg;
    if (stop) begin
      state_next = STOPPED;
    end else if (start) begin
      state_next = RUN;
    end
  end

  // A due step is dropped whenever load or stop lands on the same edge
  always_comb begin
    step_due     = (state_reg == RUN) && (div_cnt_reg == DIV_LAST) && !load && !stop;
    distance_inc = {1'b0, distance_reg} + 9'd1;
  end

  always_comb begin
    div_cnt_next = div_cnt_reg;
    if (load) begin
      div_cnt_next = '0;
    end else if (state_reg == RUN) begin
      if (stop || step_due) begin
        div_cnt_next = '0;
      end else begin
        div_cnt_next = div_cnt_reg + DIV_ONE;
      end
    end else if (start && !stop) begin
      div_cnt_next = '0;
    end
  end

  always_comb begin
    rot_in_next    = rot_in_reg;
    distance_next  = distance_reg;
    direction_next = direction_reg;
    if (load) begin
      rot_in_next   = load_data;
      distance_next = 8'd0;
    end else if (step_due) begin
      distance_next = (distance_inc == WRAP_AT) ? 8'd0 : distance_inc[7:0];
    end
    if (dir_toggle) begin
      direction_next = ~direction_reg;
    end
  end

  // Capture lags every rotator-input change by one edge so rot_out has settled
  always_comb begin
    capture_next      = load || step_due || dir_toggle;
    capture_step_next = step_due;
    pattern_next      = capture_reg ? rot_out : pattern_reg;
    step_done_next    = capture_step_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg      <= '0;
      rot_in_reg       <= '0;
      distance_reg     <= 8'd0;
      direction_reg    <= 1'b0;
      capture_reg      <= 1'b0;
      capture_step_reg <= 1'b0;
      pattern_reg      <= '0;
      step_done_reg    <= 1'b0;
    end else begin
      div_cnt_reg      <= div_cnt_next;
      rot_in_reg       <= rot_in_next;
      distance_reg     <= distance_next;
      direction_reg    <= direction_next;
      capture_reg      <= capture_next;
      capture_step_reg <= capture_step_next;
      pattern_reg      <= pattern_next;
      step_done_reg    <= step_done_next;
    end
  end

  always_comb begin
    rot_in    = rot_in_reg;
    distance  = distance_reg;
    direction = direction_reg;
    pattern   = pattern_reg;
    step_done = step_done_reg;
    running   = (state_reg == RUN);
  end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer: an 8-bit/STEP_DIV=4 instance and a
// 32-bit/STEP_DIV=1 instance, each paired with a behavioural rotator.
module tb_rotate_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH 8, STEP_DIV 4
  logic        rst_a, load_a, start_a, stop_a, tog_a;
  logic [7:0]  load_data_a, rot_out_a, rot_in_a, pattern_a, distance_a;
  logic        direction_a, step_done_a, running_a;

  // Instance B: WIDTH 32, STEP_DIV 1
  logic        rst_b, load_b, start_b, stop_b, tog_b;
  logic [31:0] load_data_b, rot_out_b, rot_in_b, pattern_b;
  logic [7:0]  distance_b;
  logic        direction_b, step_done_b, running_b;

  rotate_sequencer #(.WIDTH(8), .STEP_DIV(4)) dut_a (
    .clk(clk), .reset(rst_a), .load(load_a), .load_data(load_data_a),
    .start(start_a), .stop(stop_a), .dir_toggle(tog_a), .rot_out(rot_out_a),
    .rot_in(rot_in_a), .distance(distance_a), .direction(direction_a),
    .pattern(pattern_a), .step_done(step_done_a), .running(running_a)
  );

  rotate_sequencer #(.WIDTH(32), .STEP_DIV(1)) dut_b (
    .clk(clk), .reset(rst_b), .load(load_b), .load_data(load_data_b),
    .start(start_b), .stop(stop_b), .dir_toggle(tog_b), .rot_out(rot_out_b),
    .rot_in(rot_in_b), .distance(distance_b), .direction(direction_b),
    .pattern(pattern_b), .step_done(step_done_b), .running(running_b)
  );

  // Behavioural rotators: one bit position per iteration
  function automatic logic [7:0] rot8(input logic [7:0] x, input logic [7:0] d, input logic left);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < int'(d); i++) r = left ? {r[6:0], r[7]} : {r[0], r[7:1]};
    return r;
  endfunction

  function automatic logic [31:0] rot32(input logic [31:0] x, input logic [7:0] d, input logic left);
    logic [31:0] r;
    r = x;
    for (int i = 0; i < int'(d); i++) r = left ? {r[30:0], r[31]} : {r[0], r[31:1]};
    return r;
  endfunction

  always_comb rot_out_a = rot8(rot_in_a, distance_a, direction_a);
  always_comb rot_out_b = rot32(rot_in_b, distance_b, direction_b);

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    cyc(2);
    checks++;
    if ({rot_in_a, distance_a, direction_a, pattern_a, step_done_a, running_a} !== '0) begin
      errors++;
      $display("FAIL reset_a got rot_in=%h dist=%0d dir=%b pat=%h sd=%b run=%b want all 0",
               rot_in_a, distance_a, direction_a, pattern_a, step_done_a, running_a);
    end
    checks++;
    if ({rot_in_b, distance_b, direction_b, pattern_b, step_done_b, running_b} !== '0) begin
      errors++;
      $display("FAIL reset_b got rot_in=%h dist=%0d dir=%b pat=%h sd=%b run=%b want all 0",
               rot_in_b, distance_b, direction_b, pattern_b, step_done_b, running_b);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    cyc(1);
    $display("test_reset done");
  endtask

  task automatic test_load;
    load_a = 1'b1; load_data_a = 8'b0001_0000;
    cyc(1);
    load_a = 1'b0;
    checks++;
    if ({rot_in_a, distance_a, pattern_a} !== {8'h10, 8'd0, 8'h00}) begin
      errors++;
      $display("FAIL load_edge got rot_in=%h dist=%0d pat=%h want 10/0/00", rot_in_a, distance_a, pattern_a);
    end
    cyc(1);
    checks++;
    if ({pattern_a, step_done_a} !== {8'h10, 1'b0}) begin
      errors++;
      $display("FAIL load_capture got pat=%h sd=%b want 10/0", pattern_a, step_done_a);
    end
    $display("test_load done");
  endtask

  task automatic test_step;
    start_a = 1'b1;
    cyc(1);
    start_a = 1'b0;
    checks++;
    if ({running_a, distance_a} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL start got run=%b dist=%0d want 1/0", running_a, distance_a);
    end
    cyc(3);
    checks++;
    if ({distance_a, step_done_a} !== {8'd0, 1'b0}) begin
      errors++;
      $display("FAIL early_step got dist=%0d sd=%b want 0/0", distance_a, step_done_a);
    end
    cyc(1);
    checks++;
    if ({distance_a, pattern_a, step_done_a} !== {8'd1, 8'h10, 1'b0}) begin
      errors++;
      $display("FAIL step1_edge got dist=%0d pat=%h sd=%b want 1/10/0", distance_a, pattern_a, step_done_a);
    end
    cyc(1);
    checks++;
    if ({pattern_a, step_done_a} !== {8'b0000_1000, 1'b1}) begin
      errors++;
      $display("FAIL step1_capture got pat=%h sd=%b want 08/1", pattern_a, step_done_a);
    end
    cyc(1);
    checks++;
    if (step_done_a !== 1'b0) begin
      errors++;
      $display("FAIL step1_pulse_width got sd=%b want 0", step_done_a);
    end
    cyc(2);
    checks++;
    if (distance_a !== 8'd2) begin
      errors++;
      $display("FAIL step2_edge got dist=%0d want 2", distance_a);
    end
    cyc(1);
    checks++;
    if ({pattern_a, step_done_a} !== {8'b0000_0100, 1'b1}) begin
      errors++;
      $display("FAIL step2_capture got pat=%h sd=%b want 04/1", pattern_a, step_done_a);
    end
    $display("test_step done");
  endtask

  // Steps 3..10: passes through the wrap at step 8 and ends at distance 2
  task automatic test_wrap;
    logic [7:0] exp_dist [8];
    logic [7:0] exp_pat  [8];
    exp_dist = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1, 8'd2};
    exp_pat  = '{8'h02, 8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04};
    for (int k = 0; k < 8; k++) begin
      cyc(3);
      checks++;
      if (distance_a !== exp_dist[k]) begin
        errors++;
        $display("FAIL wrap_dist step %0d got %0d want %0d", k + 3, distance_a, exp_dist[k]);
      end
      cyc(1);
      checks++;
      if ({pattern_a, step_done_a} !== {exp_pat[k], 1'b1}) begin
        errors++;
        $display("FAIL wrap_pat step %0d got pat=%h sd=%b want %h/1", k + 3, pattern_a, step_done_a, exp_pat[k]);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_direction;
    tog_a = 1'b1;
    cyc(1);
    tog_a = 1'b0;
    checks++;
    if ({direction_a, distance_a} !== {1'b1, 8'd2}) begin
      errors++;
      $display("FAIL toggle_edge got dir=%b dist=%0d want 1/2", direction_a, distance_a);
    end
    cyc(1);
    checks++;
    if ({pattern_a, step_done_a} !== {8'b0100_0000, 1'b0}) begin
      errors++;
      $display("FAIL toggle_capture got pat=%h sd=%b want 40/0", pattern_a, step_done_a);
    end
    cyc(1);
    checks++;
    if (distance_a !== 8'd3) begin
      errors++;
      $display("FAIL left_step_edge got dist=%0d want 3", distance_a);
    end
    cyc(1);
    checks++;
    if ({pattern_a, step_done_a} !== {8'b1000_0000, 1'b1}) begin
      errors++;
      $display("FAIL left_step_capture got pat=%h sd=%b want 80/1", pattern_a, step_done_a);
    end
    $display("test_direction done");
  endtask

  task automatic test_conflicts;
    cyc(2);
    load_a = 1'b1; load_data_a = 8'h81;
    cyc(1);
    load_a = 1'b0;
    checks++;
    if ({rot_in_a, distance_a, running_a, step_done_a} !== {8'h81, 8'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_vs_step got rot_in=%h dist=%0d run=%b sd=%b want 81/0/1/0",
               rot_in_a, distance_a, running_a, step_done_a);
    end
    cyc(1);
    checks++;
    if ({pattern_a, step_done_a} !== {8'h81, 1'b0}) begin
      errors++;
      $display("FAIL load_vs_step_capture got pat=%h sd=%b want 81/0", pattern_a, step_done_a);
    end
    stop_a = 1'b1; start_a = 1'b1;
    cyc(1);
    stop_a = 1'b0; start_a = 1'b0;
    checks++;
    if (running_a !== 1'b0) begin
      errors++;
      $display("FAIL stop_start got run=%b want 0", running_a);
    end
    cyc(6);
    checks++;
    if ({running_a, distance_a, step_done_a} !== {1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL stopped_frozen got run=%b dist=%0d sd=%b want 0/0/0", running_a, distance_a, step_done_a);
    end
    // stop arriving on the edge a step is due
    start_a = 1'b1;
    cyc(1);
    start_a = 1'b0;
    cyc(3);
    stop_a = 1'b1;
    cyc(1);
    stop_a = 1'b0;
    checks++;
    if ({running_a, distance_a, direction_a} !== {1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL stop_vs_step got run=%b dist=%0d dir=%b want 0/0/1", running_a, distance_a, direction_a);
    end
    cyc(1);
    checks++;
    if ({pattern_a, step_done_a} !== {8'h81, 1'b0}) begin
      errors++;
      $display("FAIL stop_vs_step_after got pat=%h sd=%b want 81/0", pattern_a, step_done_a);
    end
    $display("test_conflicts done");
  endtask

  task automatic test_reset_mid_run;
    start_a = 1'b1;
    cyc(1);
    start_a = 1'b0;
    cyc(20);
    checks++;
    if ({running_a, distance_a} !== {1'b1, 8'd5}) begin
      errors++;
      $display("FAIL pre_reset got run=%b dist=%0d want 1/5", running_a, distance_a);
    end
    rst_a = 1'b1;
    cyc(1);
    rst_a = 1'b0;
    checks++;
    if ({rot_in_a, distance_a, direction_a, pattern_a, step_done_a, running_a} !== '0) begin
      errors++;
      $display("FAIL mid_run_reset got rot_in=%h dist=%0d dir=%b pat=%h sd=%b run=%b want all 0",
               rot_in_a, distance_a, direction_a, pattern_a, step_done_a, running_a);
    end
    cyc(1);
    checks++;
    if ({pattern_a, step_done_a} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_capture got pat=%h sd=%b want 00/0", pattern_a, step_done_a);
    end
    cyc(8);
    checks++;
    if ({running_a, distance_a, step_done_a} !== {1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_idle got run=%b dist=%0d sd=%b want 0/0/0", running_a, distance_a, step_done_a);
    end
    $display("test_reset_mid_run done");
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_pat;
    load_b = 1'b1; load_data_b = 32'h0000_0001; tog_b = 1'b1;
    cyc(1);
    load_b = 1'b0; tog_b = 1'b0;
    checks++;
    if ({rot_in_b, distance_b, direction_b} !== {32'h1, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_load got rot_in=%h dist=%0d dir=%b want 1/0/1", rot_in_b, distance_b, direction_b);
    end
    cyc(1);
    checks++;
    if ({pattern_b, step_done_b} !== {32'h1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_load_capture got pat=%h sd=%b want 1/0", pattern_b, step_done_b);
    end
    start_b = 1'b1;
    cyc(1);
    start_b = 1'b0;
    checks++;
    if ({running_b, distance_b, step_done_b} !== {1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_start got run=%b dist=%0d sd=%b want 1/0/0", running_b, distance_b, step_done_b);
    end
    cyc(1);
    checks++;
    if ({distance_b, step_done_b} !== {8'd1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first_step got dist=%0d sd=%b want 1/0", distance_b, step_done_b);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      exp_pat = 32'h1 << i;
      checks++;
      if ({pattern_b, step_done_b, distance_b} !== {exp_pat, 1'b1, 8'(i + 1)}) begin
        errors++;
        $display("FAIL b2b_step %0d got pat=%h sd=%b dist=%0d want %h/1/%0d",
                 i, pattern_b, step_done_b, distance_b, exp_pat, i + 1);
      end
    end
    stop_b = 1'b1;
    cyc(1);
    stop_b = 1'b0;
    checks++;
    if (running_b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop got run=%b want 0", running_b);
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    rst_a = 1'b1; load_a = 1'b0; start_a = 1'b0; stop_a = 1'b0; tog_a = 1'b0; load_data_a = '0;
    rst_b = 1'b1; load_b = 1'b0; start_b = 1'b0; stop_b = 1'b0; tog_b = 1'b0; load_data_b = '0;
    test_reset();
    test_load();
    test_step();
    test_wrap();
    test_direction();
    test_conflicts();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
